// File: rtl/huffman_stream_decoder_if.sv
// Stream bundle for the Huffman decoder: chunked bits in and
// signed symbols out, each with its own ready/valid pair.
interface huffman_stream_decoder_if #(
    parameter int IN_W  = 4,
    parameter int SYM_W = 4
);
    logic                        sValid;
    logic                        sReady;
    logic [IN_W-1:0]             in_bits;
    logic [$clog2(IN_W+1)-1:0]   in_len;
    logic signed [SYM_W-1:0]     decodedData;
    logic                        tvalid;
    logic                        tready;

    modport master (
        output sValid, in_bits, in_len, tready,
        input  sReady, decodedData, tvalid
    );

    modport slave (
        input  sValid, in_bits, in_len, tready,
        output sReady, decodedData, tvalid
    );
endinterface

// File: rtl/huffman_stream_decoder.sv
// Streaming prefix-code decoder: MSB-first bit buffer, run-time
// loadable code table, one symbol per cycle with backpressure.
module huffman_stream_decoder #(
    parameter int IN_W     = 4,
    parameter int MAX_CODE = 9,
    parameter int SYM_W    = 4,
    parameter int NUM_SYM  = 8,
    parameter int BUF_W    = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    huffman_stream_decoder_if.slave       io,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_SYM)-1:0]    cfg_idx,
    input  logic [MAX_CODE-1:0]           cfg_code,
    input  logic [$clog2(MAX_CODE+1)-1:0] cfg_len,
    input  logic signed [SYM_W-1:0]       cfg_sym,
    input  logic                          flush,
    output logic                          err
);
    localparam int CL_W  = $clog2(MAX_CODE+1);
    localparam int CNT_W = $clog2(BUF_W+1);

    typedef enum logic {
        RUN = 1'b0,
        ERR = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [BUF_W-1:0]        buf_q, buf_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    tvalid_q, tvalid_d;
    logic signed [SYM_W-1:0] data_q, data_d;

    logic [MAX_CODE-1:0]     tbl_code [NUM_SYM];
    logic [CL_W-1:0]         tbl_len  [NUM_SYM];
    logic signed [SYM_W-1:0] tbl_sym  [NUM_SYM];
    logic [MAX_CODE-1:0]     code_mask;

    logic                    hit;
    logic [CL_W-1:0]         hit_len;
    logic signed [SYM_W-1:0] hit_sym;

    logic                    s_ready;
    logic                    free;
    logic                    accept;
    logic [CNT_W-1:0]        use_len;
    logic [CNT_W-1:0]        app_len;
    logic [BUF_W-1:0]        chunk;

    // Codes are stored masked so stray high bits never block a match.
    assign code_mask = ~({MAX_CODE{1'b1}} << cfg_len);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_SYM; i++) begin
                tbl_code[i] <= '0;
                tbl_len[i]  <= '0;
                tbl_sym[i]  <= '0;
            end
        end else if (cfg_we && (32'(cfg_idx) < NUM_SYM)) begin
            tbl_code[cfg_idx] <= cfg_code & code_mask;
            tbl_len[cfg_idx]  <= cfg_len;
            tbl_sym[cfg_idx]  <= cfg_sym;
        end
    end

    // Scan high to low so the lowest matching index is the one kept.
    always_comb begin
        hit     = 1'b0;
        hit_len = '0;
        hit_sym = '0;
        for (int i = NUM_SYM - 1; i >= 0; i--) begin
            if ((tbl_len[i] != '0) &&
                (32'(tbl_len[i]) <= 32'(cnt_q)) &&
                ((buf_q >> (BUF_W - 32'(tbl_len[i]))) ==
                 BUF_W'(tbl_code[i]))) begin
                hit     = 1'b1;
                hit_len = tbl_len[i];
                hit_sym = tbl_sym[i];
            end
        end
    end

    assign s_ready = (state_q == RUN) &&
                     (32'(cnt_q) + IN_W <= BUF_W);

    always_comb begin
        state_d  = state_q;
        tvalid_d = tvalid_q;
        data_d   = data_q;
        use_len  = '0;
        app_len  = '0;
        chunk    = '0;
        free     = !tvalid_q || io.tready;
        accept   = io.sValid && s_ready;

        unique case (state_q)
            RUN: begin
                if (free && hit) begin
                    data_d   = hit_sym;
                    tvalid_d = 1'b1;
                    use_len  = CNT_W'(hit_len);
                end else if (io.tready) begin
                    tvalid_d = 1'b0;
                end
                if (!hit && (32'(cnt_q) >= MAX_CODE)) begin
                    state_d = ERR;
                end
            end
            ERR: begin
                if (io.tready) begin
                    tvalid_d = 1'b0;
                end
            end
        endcase

        // Left-justify the chunk so bits above in_len fall off the top.
        if (accept) begin
            app_len = (32'(io.in_len) > IN_W) ? CNT_W'(IN_W)
                                               : CNT_W'(io.in_len);
            chunk   = {io.in_bits, {(BUF_W-IN_W){1'b0}}}
                      << (IN_W - 32'(app_len));
        end

        buf_d = (buf_q << use_len) | (chunk >> (cnt_q - use_len));
        cnt_d = cnt_q - use_len + app_len;

        if (flush) begin
            state_d  = RUN;
            tvalid_d = 1'b0;
            buf_d    = '0;
            cnt_d    = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= RUN;
            buf_q    <= '0;
            cnt_q    <= '0;
            tvalid_q <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            buf_q    <= buf_d;
            cnt_q    <= cnt_d;
            tvalid_q <= tvalid_d;
            data_q   <= data_d;
        end
    end

    assign io.sReady      = s_ready;
    assign io.tvalid      = tvalid_q;
    assign io.decodedData = data_q;
    assign err            = (state_q == ERR);
endmodule
